// File: rtl/data_demod_if.sv
//==============================================================================
// Module      : data_demod_if
// Description : Symbol-in / byte-out handshake bundle for the 5-bit demodulator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface data_demod_if;
    logic [4:0] dmod;
    logic       mod_en;
    logic       flush;
    logic       full;
    logic       wr;
    logic [7:0] data_out;
    logic       ovf;
    logic [4:0] cnt;

    modport master (
        output dmod, mod_en, flush, full,
        input  wr, data_out, ovf, cnt
    );

    modport slave (
        input  dmod, mod_en, flush, full,
        output wr, data_out, ovf, cnt
    );
endinterface

`default_nettype wire

// File: rtl/data_demod.sv
//==============================================================================
// Module      : data_demod
// Description : Repacks LSB-first 5-bit symbols into bytes for a write/full FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_demod (
    input  wire logic   clk,
    input  wire logic   reset_n,
    data_demod_if.slave bus
);

    localparam logic [4:0] c_BYTE_BITS  = 5'd8;
    localparam logic [4:0] c_SYM_BITS   = 5'd5;
    localparam logic [4:0] c_ACCEPT_MAX = 5'd11;

    logic [15:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_ovf;

    logic        w_wr;
    logic [4:0]  w_cnt_w;
    logic        w_acc_en;
    logic        w_reject;
    logic [15:0] w_acc_shift;
    logic [15:0] w_acc_next;
    logic [4:0]  w_cnt_next;
    logic        w_ovf_next;

    assign w_wr     = (r_cnt >= c_BYTE_BITS) & ~bus.full & ~bus.flush;
    assign w_cnt_w  = w_wr ? (r_cnt - c_BYTE_BITS) : r_cnt;
    // Accepting at c_w <= 11 keeps the inserted symbol within the 16-bit accumulator.
    assign w_acc_en = bus.mod_en & ~bus.flush & (w_cnt_w <= c_ACCEPT_MAX);
    assign w_reject = bus.mod_en & ~bus.flush & (w_cnt_w > c_ACCEPT_MAX);

    always_comb begin
        w_acc_shift = w_wr ? {8'h00, r_acc[15:8]} : r_acc;
        w_acc_next  = w_acc_shift;
        w_cnt_next  = w_cnt_w;
        w_ovf_next  = r_ovf | w_reject;
        if (w_acc_en) begin
            w_acc_next = w_acc_shift | ({11'h000, bus.dmod} << w_cnt_w);
            w_cnt_next = w_cnt_w + c_SYM_BITS;
        end
        if (bus.flush) begin
            w_acc_next = 16'h0000;
            w_cnt_next = 5'd0;
            w_ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= 16'h0000;
            r_cnt <= 5'd0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
        end
    end

    assign bus.wr       = w_wr;
    assign bus.data_out = r_acc[7:0];
    assign bus.ovf      = r_ovf;
    assign bus.cnt      = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_data_demod.sv
//==============================================================================
// Module      : tb_data_demod
// Description : Randomized self-checking bench for data_demod against a bit-queue model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_data_demod;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    data_demod_if dif ();

    data_demod dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference: buffered stream bits, oldest first.
    bit q[$];
    bit m_ovf;

    bit [7:0] lb_bytes [1000];
    bit [4:0] lb_syms  [1600];

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] d, input logic m, input logic fu, input logic fl,
                              output logic e_wr, output logic [7:0] e_data);
        e_wr   = 1'b0;
        e_data = 8'h00;
        for (int i = 0; i < 8; i++)
            if (i < q.size()) e_data[i] = q[i];
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (q.size() >= 8 && !fu) begin
                e_wr = 1'b1;
                repeat (8) void'(q.pop_front());
            end
            if (m) begin
                if (q.size() <= 11) begin
                    for (int i = 0; i < 5; i++) q.push_back(d[i]);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    // Called just after a rising edge; samples combinational outputs mid-cycle.
    task automatic drive(input logic [4:0] d, input logic m, input logic fu, input logic fl,
                         output logic o_wr, output logic [7:0] o_data);
        dif.dmod   = d;
        dif.mod_en = m;
        dif.full   = fu;
        dif.flush  = fl;
        #3;
        o_wr   = dif.wr;
        o_data = dif.data_out;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        dif.dmod = 5'h1F; dif.mod_en = 1'b1; dif.full = 1'b0; dif.flush = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (dif.cnt !== 5'd0)        begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dif.cnt); end
        if (dif.wr !== 1'b0)         begin errors++; $display("FAIL reset_wr: got %b expected 0", dif.wr); end
        if (dif.ovf !== 1'b0)        begin errors++; $display("FAIL reset_ovf: got %b expected 0", dif.ovf); end
        if (dif.data_out !== 8'h00)  begin errors++; $display("FAIL reset_data: got %h expected 00", dif.data_out); end
        dif.mod_en = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [4:0] syms [8];
        logic [7:0] exp_b [5];
        logic [7:0] got [$];
        logic w, ew;
        logic [7:0] dat, ed;
        int first = -1;
        syms  = '{5'h05, 5'h05, 5'h0F, 5'h1E, 5'h0F, 5'h00, 5'h04, 5'h10};
        exp_b = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
        for (int c = 0; c < 12; c++) begin
            drive(c < 8 ? syms[c] : 5'h00, c < 8, 1'b0, 1'b0, w, dat);
            model_step(c < 8 ? syms[c] : 5'h00, c < 8, 1'b0, 1'b0, ew, ed);
            checks++;
            if (w !== ew) begin errors++; $display("FAIL basic_wr cycle %0d: got %b expected %b", c, w, ew); end
            if (w === 1'b1) begin
                got.push_back(dat);
                if (first < 0) first = c;
            end
        end
        checks += 4;
        if (got.size() != 5) begin errors++; $display("FAIL basic_count: got %0d expected 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_b[i]);
            end
        end
        if (first != 2)            begin errors++; $display("FAIL basic_latency: got %0d expected 2", first); end
        if (dif.cnt !== 5'd0)      begin errors++; $display("FAIL basic_cnt: got %0d expected 0", dif.cnt); end
        if (dif.ovf !== 1'b0)      begin errors++; $display("FAIL basic_ovf: got %b expected 0", dif.ovf); end
    endtask

    task automatic test_backpressure();
        logic [4:0] s [5];
        logic [4:0] exp_cnt [5];
        logic       exp_ovf [5];
        logic w, ew;
        logic [7:0] dat, ed;
        exp_cnt = '{5'd5, 5'd10, 5'd15, 5'd15, 5'd15};
        exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        drive(5'h00, 1'b0, 1'b0, 1'b1, w, dat);
        model_step(5'h00, 1'b0, 1'b0, 1'b1, ew, ed);
        for (int i = 0; i < 5; i++) s[i] = 5'($urandom);
        for (int i = 0; i < 5; i++) begin
            drive(s[i], 1'b1, 1'b1, 1'b0, w, dat);
            model_step(s[i], 1'b1, 1'b1, 1'b0, ew, ed);
            checks += 3;
            if (w !== 1'b0) begin errors++; $display("FAIL bp_wr%0d: got %b expected 0", i, w); end
            if (dif.cnt !== exp_cnt[i]) begin errors++; $display("FAIL bp_cnt%0d: got %0d expected %0d", i, dif.cnt, exp_cnt[i]); end
            if (dif.ovf !== exp_ovf[i]) begin errors++; $display("FAIL bp_ovf%0d: got %b expected %b", i, dif.ovf, exp_ovf[i]); end
        end
        drive(5'h00, 1'b0, 1'b0, 1'b0, w, dat);
        model_step(5'h00, 1'b0, 1'b0, 1'b0, ew, ed);
        checks += 4;
        if (w !== 1'b1) begin errors++; $display("FAIL bp_release_wr: got %b expected 1", w); end
        if (dat !== {s[1][2:0], s[0]}) begin errors++; $display("FAIL bp_release_data: got %h expected %h", dat, {s[1][2:0], s[0]}); end
        if (dif.cnt !== 5'd7) begin errors++; $display("FAIL bp_release_cnt: got %0d expected 7", dif.cnt); end
        if (dif.ovf !== 1'b1) begin errors++; $display("FAIL bp_sticky_ovf: got %b expected 1", dif.ovf); end
    endtask

    task automatic test_simultaneous();
        logic [4:0] s0, s1;
        logic w, ew;
        logic [7:0] dat, ed;
        s0 = 5'($urandom);
        s1 = 5'($urandom);
        drive(5'h00, 1'b0, 1'b0, 1'b1, w, dat);
        model_step(5'h00, 1'b0, 1'b0, 1'b1, ew, ed);
        drive(s0, 1'b1, 1'b1, 1'b0, w, dat);
        model_step(s0, 1'b1, 1'b1, 1'b0, ew, ed);
        drive(s1, 1'b1, 1'b1, 1'b0, w, dat);
        model_step(s1, 1'b1, 1'b1, 1'b0, ew, ed);
        drive(5'h1F, 1'b1, 1'b0, 1'b0, w, dat);
        model_step(5'h1F, 1'b1, 1'b0, 1'b0, ew, ed);
        checks += 3;
        if (w !== 1'b1) begin errors++; $display("FAIL simul_wr: got %b expected 1", w); end
        if (dat !== {s1[2:0], s0}) begin errors++; $display("FAIL simul_data: got %h expected %h", dat, {s1[2:0], s0}); end
        if (dif.cnt !== 5'd7) begin errors++; $display("FAIL simul_cnt: got %0d expected 7", dif.cnt); end
        drive(5'h00, 1'b1, 1'b0, 1'b0, w, dat);
        model_step(5'h00, 1'b1, 1'b0, 1'b0, ew, ed);
        checks += 2;
        if (w !== 1'b0) begin errors++; $display("FAIL simul_wr2: got %b expected 0", w); end
        if (dif.cnt !== 5'd12) begin errors++; $display("FAIL simul_cnt2: got %0d expected 12", dif.cnt); end
        drive(5'h00, 1'b0, 1'b0, 1'b0, w, dat);
        model_step(5'h00, 1'b0, 1'b0, 1'b0, ew, ed);
        checks += 3;
        if (w !== 1'b1) begin errors++; $display("FAIL simul_wr3: got %b expected 1", w); end
        if (dat !== {1'b0, 5'h1F, s1[4:3]}) begin errors++; $display("FAIL simul_insert: got %h expected %h", dat, {1'b0, 5'h1F, s1[4:3]}); end
        if (dif.cnt !== 5'd4) begin errors++; $display("FAIL simul_cnt3: got %0d expected 4", dif.cnt); end
    endtask

    task automatic test_flush();
        logic       fu_seq [10];
        logic w, ew;
        logic [7:0] dat, ed;
        logic [4:0] d;
        fu_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        drive(5'h00, 1'b0, 1'b0, 1'b1, w, dat);
        model_step(5'h00, 1'b0, 1'b0, 1'b1, ew, ed);
        for (int i = 0; i < 10; i++) begin
            d = 5'($urandom);
            drive(d, 1'b1, fu_seq[i], 1'b0, w, dat);
            model_step(d, 1'b1, fu_seq[i], 1'b0, ew, ed);
            checks += 2;
            if (w !== ew) begin errors++; $display("FAIL flush_setup_wr%0d: got %b expected %b", i, w, ew); end
            if (dif.cnt !== 5'(q.size())) begin errors++; $display("FAIL flush_setup_cnt%0d: got %0d expected %0d", i, dif.cnt, q.size()); end
        end
        checks += 2;
        if (dif.cnt !== 5'd13) begin errors++; $display("FAIL flush_pre_cnt: got %0d expected 13", dif.cnt); end
        if (dif.ovf !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf: got %b expected 1", dif.ovf); end
        d = 5'($urandom);
        drive(d, 1'b1, 1'b0, 1'b1, w, dat);
        model_step(d, 1'b1, 1'b0, 1'b1, ew, ed);
        checks += 3;
        if (w !== 1'b0) begin errors++; $display("FAIL flush_wr: got %b expected 0", w); end
        if (dif.cnt !== 5'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", dif.cnt); end
        if (dif.ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b expected 0", dif.ovf); end
        drive(d, 1'b1, 1'b1, 1'b0, w, dat);
        model_step(d, 1'b1, 1'b1, 1'b0, ew, ed);
        checks++;
        if (dif.cnt !== 5'd5) begin errors++; $display("FAIL flush_after_cnt: got %0d expected 5", dif.cnt); end
    endtask

    task automatic test_async_reset();
        logic w, ew;
        logic [7:0] dat, ed;
        drive(5'h00, 1'b0, 1'b0, 1'b1, w, dat);
        model_step(5'h00, 1'b0, 1'b0, 1'b1, ew, ed);
        for (int i = 0; i < 4; i++) begin
            drive(5'($urandom), 1'b1, (i != 2), 1'b0, w, dat);
            model_step(5'h00, 1'b1, (i != 2), 1'b0, ew, ed);
        end
        checks++;
        if (dif.cnt !== 5'd12) begin errors++; $display("FAIL arst_pre_cnt: got %0d expected 12", dif.cnt); end
        dif.mod_en = 1'b0; dif.full = 1'b0; dif.flush = 1'b0;
        #2;
        checks++;
        if (dif.wr !== 1'b1) begin errors++; $display("FAIL arst_pre_wr: got %b expected 1", dif.wr); end
        reset_n = 1'b0;
        #1;
        checks += 3;
        if (dif.cnt !== 5'd0) begin errors++; $display("FAIL arst_cnt: got %0d expected 0", dif.cnt); end
        if (dif.wr !== 1'b0) begin errors++; $display("FAIL arst_wr: got %b expected 0", dif.wr); end
        if (dif.ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b expected 0", dif.ovf); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_loopback();
        logic w, ew, fu, m;
        logic [7:0] dat, ed;
        logic [4:0] d;
        int idx = 0, rx = 0, cyc = 0, cw;
        bit bits [8000];
        drive(5'h00, 1'b0, 1'b0, 1'b1, w, dat);
        model_step(5'h00, 1'b0, 1'b0, 1'b1, ew, ed);
        for (int b = 0; b < 1000; b++) begin
            lb_bytes[b] = 8'($urandom);
            for (int k = 0; k < 8; k++) bits[b * 8 + k] = lb_bytes[b][k];
        end
        for (int j = 0; j < 1600; j++)
            for (int k = 0; k < 5; k++) lb_syms[j][k] = bits[j * 5 + k];
        while (rx < 1000 && cyc < 20000) begin
            fu = ($urandom_range(0, 3) == 0);
            cw = (q.size() >= 8 && !fu) ? q.size() - 8 : q.size();
            m  = (idx < 1600) && (cw <= 11) && ($urandom_range(0, 3) != 0);
            d  = m ? lb_syms[idx] : 5'h00;
            drive(d, m, fu, 1'b0, w, dat);
            model_step(d, m, fu, 1'b0, ew, ed);
            if (m) idx++;
            cyc++;
            checks++;
            if (w !== ew) begin errors++; $display("FAIL loop_wr cycle %0d: got %b expected %b", cyc, w, ew); end
            if (w === 1'b1) begin
                checks++;
                if (rx >= 1000 || dat !== lb_bytes[rx]) begin
                    errors++;
                    $display("FAIL loop_byte%0d: got %h expected %h", rx, dat, (rx < 1000) ? lb_bytes[rx] : 8'hxx);
                end
                rx++;
            end
        end
        checks += 3;
        if (rx != 1000) begin errors++; $display("FAIL loop_count: got %0d expected 1000", rx); end
        if (dif.ovf !== 1'b0) begin errors++; $display("FAIL loop_ovf: got %b expected 0", dif.ovf); end
        if (dif.cnt !== 5'd0) begin errors++; $display("FAIL loop_cnt: got %0d expected 0", dif.cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dif.dmod = 5'h00; dif.mod_en = 1'b0; dif.full = 1'b0; dif.flush = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
